// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer. Loads are sign/zero extended. The data
// memory only writes whole words, so byte and half stores are read-modify-write.
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              stall,
    output logic              mem_MemWrite,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_STORE, S_RMW_RD, S_RMW_WR, S_RESP
    } state_t;

    state_t            r_state, w_next;
    logic              r_we_q;
    logic [2:0]        r_funct3_q;
    logic [ADDR_W-1:0] r_addr_q;
    logic [31:0]       r_wdata_q;
    logic [31:0]       r_old_q;
    logic [31:0]       r_rdata_q;
    logic              r_err_q;

    logic              w_accept;
    logic              w_illegal;
    logic [31:0]       w_ext;
    logic [31:0]       w_merge;

    assign w_accept   = req_valid && (r_state == S_IDLE);
    assign mem_addr   = r_addr_q;
    assign resp_rdata = r_rdata_q;
    assign resp_err   = r_err_q;
    assign stall      = ((r_state != S_IDLE) && (r_state != S_RESP)) ||
                        ((r_state == S_IDLE) && req_valid);

    // Decode the incoming request for an illegal funct3.
    always_comb begin
        w_illegal = 1'b0;
        if (req_we)
            w_illegal = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
        else
            w_illegal = !(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end

    // Load extension and sub-word merge for the RMW write.
    always_comb begin
        w_ext = 32'h0;
        case (r_funct3_q)
            3'b000:  w_ext = {{24{mem_dout[7]}}, mem_dout[7:0]};
            3'b001:  w_ext = {{16{mem_dout[15]}}, mem_dout[15:0]};
            3'b010:  w_ext = mem_dout;
            3'b100:  w_ext = {24'h0, mem_dout[7:0]};
            3'b101:  w_ext = {16'h0, mem_dout[15:0]};
            default: w_ext = 32'h0;
        endcase
        w_merge = (r_funct3_q == 3'b000) ? {r_old_q[31:8],  r_wdata_q[7:0]}
                                          : {r_old_q[31:16], r_wdata_q[15:0]};
    end

    // Next-state logic and per-state outputs.
    always_comb begin
        w_next       = r_state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        mem_MemWrite = 1'b0;
        mem_din      = 32'h0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_illegal)                  w_next = S_RESP;
                    else if (!req_we)               w_next = S_LOAD;
                    else if (req_funct3 == 3'b010)  w_next = S_STORE;
                    else                            w_next = S_RMW_RD;
                end
            end
            S_LOAD:   w_next = S_RESP;
            S_STORE: begin
                mem_MemWrite = 1'b1;
                mem_din      = r_wdata_q;
                w_next       = S_RESP;
            end
            S_RMW_RD: w_next = S_RMW_WR;
            S_RMW_WR: begin
                mem_MemWrite = 1'b1;
                mem_din      = w_merge;
                w_next       = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                w_next     = S_IDLE;
            end
            default:  w_next = S_IDLE;
        endcase
    end

    // State register, request capture and response registers.
    // rdata/err change only when a response is about to be presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_we_q     <= 1'b0;
            r_funct3_q <= 3'b0;
            r_addr_q   <= '0;
            r_wdata_q  <= 32'h0;
            r_old_q    <= 32'h0;
            r_rdata_q  <= 32'h0;
            r_err_q    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_we_q     <= req_we;
                r_funct3_q <= req_funct3;
                r_addr_q   <= req_addr;
                r_wdata_q  <= req_wdata;
                if (w_illegal) begin
                    r_rdata_q <= 32'h0;
                    r_err_q   <= 1'b1;
                end
            end
            case (r_state)
                S_LOAD: begin
                    r_rdata_q <= w_ext;
                    r_err_q   <= 1'b0;
                end
                S_STORE, S_RMW_WR: begin
                    r_rdata_q <= 32'h0;
                    r_err_q   <= 1'b0;
                end
                S_RMW_RD: r_old_q <= mem_dout;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-addressed memory model.
module tb_mem_access_unit;

    logic        clk, rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, stall, mem_MemWrite;
    logic [31:0] resp_rdata, mem_addr, mem_din, mem_dout;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0]  mem [0:1023];
    logic        poke_en;
    logic [9:0]  poke_addr;
    logic [31:0] poke_data;
    logic [9:0]  wa;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .stall(stall), .mem_MemWrite(mem_MemWrite), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational read, little-endian, byte at addr in [7:0].
    always_comb begin
        wa       = mem_addr[9:0];
        mem_dout = {mem[wa + 10'd3], mem[wa + 10'd2], mem[wa + 10'd1], mem[wa]};
    end

    // Whole-word writes from the DUT, plus a bench preload path.
    always @(posedge clk) begin
        if (mem_MemWrite) begin
            mem[wa]         <= mem_din[7:0];
            mem[wa + 10'd1] <= mem_din[15:8];
            mem[wa + 10'd2] <= mem_din[23:16];
            mem[wa + 10'd3] <= mem_din[31:24];
        end else if (poke_en) begin
            mem[poke_addr]         <= poke_data[7:0];
            mem[poke_addr + 10'd1] <= poke_data[15:8];
            mem[poke_addr + 10'd2] <= poke_data[23:16];
            mem[poke_addr + 10'd3] <= poke_data[31:24];
        end
    end

    function automatic logic [31:0] peek(input logic [9:0] a);
        return {mem[a + 10'd3], mem[a + 10'd2], mem[a + 10'd1], mem[a]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_rst(input string p);
        chk({p, " req_ready"},    32'(req_ready),    32'd1);
        chk({p, " resp_valid"},   32'(resp_valid),   32'd0);
        chk({p, " resp_rdata"},   resp_rdata,        32'd0);
        chk({p, " resp_err"},     32'(resp_err),     32'd0);
        chk({p, " stall"},        32'(stall),        32'd0);
        chk({p, " mem_MemWrite"}, 32'(mem_MemWrite), 32'd0);
        chk({p, " mem_addr"},     mem_addr,          32'd0);
        chk({p, " mem_din"},      mem_din,           32'd0);
    endtask

    // Starts and ends on a negedge.
    task automatic poke(input logic [9:0] a, input logic [31:0] d);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(posedge clk);
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // Issue one request from IDLE; report latency (cycles after accept edge),
    // write pulse count, cycle of last write and its data, and the response.
    task automatic do_req(input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output int wr_n, output int wr_k,
                          output logic [31:0] wr_din, output logic [31:0] rd,
                          output logic err);
        lat = 0; wr_n = 0; wr_k = 0; wr_din = 32'h0; rd = 32'h0; err = 1'b0;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (mem_MemWrite) begin
                wr_n++; wr_k = k; wr_din = mem_din;
            end
            if (resp_valid) begin
                lat = k; rd = resp_rdata; err = resp_err;
                break;
            end
        end
        @(negedge clk);
    endtask

    int lat, wr_n, wr_k;
    logic [31:0] wr_din, rd;
    logic err;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0; poke_en = 1'b0;
        poke_addr = 10'h0; poke_data = 32'h0;
        @(negedge clk);
        chk_rst("reset");
        poke(10'h040, 32'h11223344);
        poke(10'h100, 32'h00000080);
        poke(10'h202, 32'hCAFEF00D);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset during RMW_WR aborts the write.
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h40; req_wdata = 32'h000000AB;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rmw_wr we",  32'(mem_MemWrite), 32'd1);
        chk("rmw_wr din", mem_din, 32'h112233AB);
        rst_n = 1'b0;
        #1 chk_rst("midrst");
        @(posedge clk);
        @(negedge clk);
        chk("midrst word", peek(10'h040), 32'h11223344);
        rst_n = 1'b1;
        @(negedge clk);

        // LB / LBU of 0x80.
        do_req(1'b0, 3'b000, 32'h100, 32'h0, lat, wr_n, wr_k, wr_din, rd, err);
        chk("lb lat", 32'(lat), 32'd2);
        chk("lb rdata", rd, 32'hFFFFFF80);
        chk("lb err", 32'(err), 32'd0);
        chk("lb writes", 32'(wr_n), 32'd0);
        do_req(1'b0, 3'b100, 32'h100, 32'h0, lat, wr_n, wr_k, wr_din, rd, err);
        chk("lbu lat", 32'(lat), 32'd2);
        chk("lbu rdata", rd, 32'h00000080);

        // SH over 0xCAFEF00D.
        do_req(1'b1, 3'b001, 32'h202, 32'h1234BEEF, lat, wr_n, wr_k, wr_din, rd, err);
        chk("sh writes", 32'(wr_n), 32'd1);
        chk("sh wr cycle", 32'(wr_k), 32'd2);
        chk("sh din", wr_din, 32'hCAFEBEEF);
        chk("sh lat", 32'(lat), 32'd3);
        chk("sh rdata", rd, 32'h0);
        chk("sh word", peek(10'h202), 32'hCAFEBEEF);

        // Misaligned SW then loads.
        do_req(1'b1, 3'b010, 32'h13, 32'hDEADBEEF, lat, wr_n, wr_k, wr_din, rd, err);
        chk("sw lat", 32'(lat), 32'd2);
        chk("sw writes", 32'(wr_n), 32'd1);
        chk("sw wr cycle", 32'(wr_k), 32'd1);
        do_req(1'b0, 3'b010, 32'h13, 32'h0, lat, wr_n, wr_k, wr_din, rd, err);
        chk("lw lat", 32'(lat), 32'd2);
        chk("lw rdata", rd, 32'hDEADBEEF);
        do_req(1'b0, 3'b001, 32'h13, 32'h0, lat, wr_n, wr_k, wr_din, rd, err);
        chk("lh rdata", rd, 32'hFFFFBEEF);
        do_req(1'b0, 3'b101, 32'h13, 32'h0, lat, wr_n, wr_k, wr_din, rd, err);
        chk("lhu rdata", rd, 32'h0000BEEF);

        // Illegal funct3.
        do_req(1'b0, 3'b011, 32'h13, 32'h0, lat, wr_n, wr_k, wr_din, rd, err);
        chk("ill ld lat", 32'(lat), 32'd1);
        chk("ill ld err", 32'(err), 32'd1);
        chk("ill ld rdata", rd, 32'h0);
        do_req(1'b1, 3'b100, 32'h13, 32'h55555555, lat, wr_n, wr_k, wr_din, rd, err);
        chk("ill st lat", 32'(lat), 32'd1);
        chk("ill st err", 32'(err), 32'd1);
        chk("ill st writes", 32'(wr_n), 32'd0);
        chk("ill st word", peek(10'h013), 32'hDEADBEEF);

        // Back-to-back with req_valid held high.
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h13;
        @(posedge clk);
        @(negedge clk);
        chk("b2b load stall", 32'(stall), 32'd1);
        chk("b2b load ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("b2b resp valid", 32'(resp_valid), 32'd1);
        chk("b2b resp stall", 32'(stall), 32'd0);
        chk("b2b resp ready", 32'(req_ready), 32'd0);
        chk("b2b rdata1", resp_rdata, 32'hDEADBEEF);
        req_funct3 = 3'b100; req_addr = 32'h100;
        @(negedge clk);
        chk("b2b idle ready", 32'(req_ready), 32'd1);
        chk("b2b idle stall", 32'(stall), 32'd1);
        chk("b2b idle rv", 32'(resp_valid), 32'd0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("b2b2 n+1 rv", 32'(resp_valid), 32'd0);
        @(negedge clk);
        chk("b2b2 rv", 32'(resp_valid), 32'd1);
        chk("b2b2 rdata", resp_rdata, 32'h00000080);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
